// File: rtl/popcnt_pkg.sv
// Shared types and helpers for the streaming population counter.
// Holds the frame FSM state encoding and the popcount width function.
package popcnt_pkg;

   // ACC: frame being accumulated; HOLD: frame result presented downstream.
   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Bits needed to hold a popcount of a data_w-bit word (0..data_w).
   function automatic int cnt_w(input int data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/popcnt_word.sv
// Combinational population count of one DATA_W-bit word.
// The per-bit sum is written as a flat loop; synthesis balances it into a tree.
module popcnt_word
   import popcnt_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int CNT_W  = cnt_w(DATA_W)
) (
   input  logic [DATA_W-1:0] data,
   output logic [CNT_W-1:0]  cnt
);

   // Sum of all set bits in the word.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < DATA_W; i++) begin
         cnt = cnt + CNT_W'(data[i]);
      end
   end

endmodule

// File: rtl/popcnt_stream.sv
// Frame-based streaming population counter.
// S1 registers the popcount of each accepted word; the frame FSM accumulates
// S1 beats until in_last and then presents the frame sum and word count.
// Build option: define POPCNT_SAT_EN to saturate the sum and word count at
// all-ones and report it on out_ovf; otherwise both wrap and out_ovf is 0.
// Handshakes: a beat moves on either side only in a cycle where valid and
// ready are both high at the rising edge; a producer holding valid must keep
// its data stable until ready, and this block keeps out_* stable while
// out_valid is high and out_ready is low.
module popcnt_stream
   import popcnt_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 16,
   parameter int WCNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [WCNT_W-1:0] out_words,
   output logic              out_ovf
);

   localparam int CNT_W = cnt_w(DATA_W);

   state_t              state_q, state_d;
   logic                v_q;
   logic                last_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    word_cnt;
   logic                accept, adv;
   logic                first_q, first_d;
   logic                load_acc, load_out;
   logic [ACC_W-1:0]    acc_q, base_sum, nsum;
   logic [WCNT_W-1:0]   words_q, base_words, nwords;

   popcnt_word #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_word (
      .data (in_data),
      .cnt  (word_cnt)
   );

   assign adv       = v_q && (state_q == ACC || out_ready);
   assign in_ready  = rst_n && (!v_q || adv);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == HOLD);

   // S1 register: capture the word's popcount on accept, drain on advance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q    <= 1'b0;
         last_q <= 1'b0;
         cnt_q  <= '0;
      end else if (accept) begin
         v_q    <= 1'b1;
         last_q <= in_last;
         cnt_q  <= word_cnt;
      end else if (adv) begin
         v_q    <= 1'b0;
      end
   end

   // Frame FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ACC;
      else        state_q <= state_d;
   end

   // Next state plus accumulate/emit strobes for the S1 beat leaving this cycle.
   always_comb begin
      state_d  = state_q;
      first_d  = first_q;
      load_acc = 1'b0;
      load_out = 1'b0;
      case (state_q)
         ACC: begin
            if (adv) begin
               if (last_q) begin
                  state_d  = HOLD;
                  load_out = 1'b1;
                  first_d  = 1'b1;
               end else begin
                  load_acc = 1'b1;
                  first_d  = 1'b0;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               if (adv && last_q) begin
                  load_out = 1'b1;
                  first_d  = 1'b1;
               end else if (adv) begin
                  state_d  = ACC;
                  load_acc = 1'b1;
                  first_d  = 1'b0;
               end else begin
                  state_d  = ACC;
               end
            end
         end
         default: state_d = ACC;
      endcase
   end

   // A new frame starts from zero rather than the stale accumulator.
   assign base_sum   = first_q ? '0 : acc_q;
   assign base_words = first_q ? '0 : words_q;

`ifdef POPCNT_SAT_EN
   logic              ovf_q, novf;
   logic [ACC_W:0]    sum_ext;
   logic [WCNT_W:0]   words_ext;

   // Saturating frame sum and word count, with sticky overflow per frame.
   always_comb begin
      sum_ext   = {1'b0, base_sum} + (ACC_W+1)'(cnt_q);
      words_ext = {1'b0, base_words} + (WCNT_W+1)'(1);
      nsum      = sum_ext[ACC_W]     ? '1 : sum_ext[ACC_W-1:0];
      nwords    = words_ext[WCNT_W]  ? '1 : words_ext[WCNT_W-1:0];
      novf      = (!first_q && ovf_q) || sum_ext[ACC_W] || words_ext[WCNT_W];
   end

   // Overflow flag tracks the frame in progress and the presented result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q   <= 1'b0;
         out_ovf <= 1'b0;
      end else begin
         if (load_acc) ovf_q   <= novf;
         if (load_out) out_ovf <= novf;
      end
   end
`else
   // Wrapping frame sum and word count.
   always_comb begin
      nsum   = base_sum + ACC_W'(cnt_q);
      nwords = base_words + WCNT_W'(1);
   end

   assign out_ovf = 1'b0;
`endif

   // Accumulator and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         first_q   <= 1'b1;
         acc_q     <= '0;
         words_q   <= '0;
         out_sum   <= '0;
         out_words <= '0;
      end else begin
         first_q <= first_d;
         if (load_acc) begin
            acc_q   <= nsum;
            words_q <= nwords;
         end
         if (load_out) begin
            out_sum   <= nsum;
            out_words <= nwords;
         end
      end
   end

endmodule

// File: tb/tb_popcnt_stream.sv
// Directed bench for popcnt_stream (DATA_W=16, ACC_W=8, WCNT_W=8).
// Frame results are checked by a handshake monitor against an expected
// queue of packed {ovf, words, sum}; cycle timing is checked inline.
module tb_popcnt_stream;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 8;
   localparam int WCNT_W = 8;
   localparam int EXP_W  = 1 + WCNT_W + ACC_W;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic [WCNT_W-1:0] out_words;
   logic              out_ovf;

   logic [EXP_W-1:0]  exp_q[$];
   int                n_checks = 0;
   int                n_errors = 0;

   popcnt_stream #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .WCNT_W (WCNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_words (out_words),
      .out_ovf   (out_ovf)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic logic [EXP_W-1:0] pack(input int sum, input int words, input logic ovf);
      logic [EXP_W-1:0] v;
      v = {ovf, WCNT_W'(words), ACC_W'(sum)};
      return v;
   endfunction

   // Scoreboard: every transferred result must match the next expected frame.
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("res_sum",   out_sum,   e[ACC_W-1:0]);
            check("res_words", out_words, e[ACC_W +: WCNT_W]);
            check("res_ovf",   out_ovf,   e[EXP_W-1]);
         end
      end
   end

   // Present one word and hold it until accepted (bounded wait).
   task automatic send_word(input logic [DATA_W-1:0] d, input logic l);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'hFFFF;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Reset held for 3 cycles with in_valid asserted.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_in_ready", in_ready, 0);
         if (i > 0) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_out_sum",   out_sum,   0);
            check("rst_out_words", out_words, 0);
            check("rst_out_ovf",   out_ovf,   0);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle();
      @(negedge clk);
      check("rel_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // Basic frame: 16 + 1 + 4 = 21 over 3 words.
      exp_q.push_back(pack(21, 3, 1'b0));
      send_word(16'hFFFF, 1'b0);
      send_word(16'h0001, 1'b0);
      send_word(16'h00F0, 1'b1);
      idle();
      @(negedge clk);
      check("basic_lat1_valid", out_valid, 0);
      @(negedge clk);
      check("basic_lat2_valid", out_valid, 1);
      check("basic_sum",        out_sum,   21);
      check("basic_words",      out_words, 3);
      @(negedge clk);
      check("basic_pulse_end",  out_valid, 0);
      @(posedge clk); #1;

      // Back-pressure: frame A (0x0101,0x8000 -> 3/2), then B (0x0007 -> 3/1),
      // then C (0x0003 -> 2/1) waiting at the input while out_ready is low.
      out_ready = 1'b0;
      exp_q.push_back(pack(3, 2, 1'b0));
      exp_q.push_back(pack(3, 1, 1'b0));
      exp_q.push_back(pack(2, 1, 1'b0));
      send_word(16'h0101, 1'b0);
      send_word(16'h8000, 1'b1);
      send_word(16'h0007, 1'b1);
      in_valid = 1'b1;
      in_data  = 16'h0003;
      in_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready",  in_ready,  0);
         check("bp_out_valid", out_valid, 1);
         check("bp_sum",       out_sum,   3);
         check("bp_words",     out_words, 2);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_word(16'h0003, 1'b1);
      idle();
      cycles(4);
      check("bp_drained", exp_q.size(), 0);

      // Back-to-back single-word frames with in_ready held high.
      exp_q.push_back(pack(4, 1, 1'b0));
      exp_q.push_back(pack(2, 1, 1'b0));
      in_valid = 1'b1;
      in_data  = 16'h000F;
      in_last  = 1'b1;
      @(negedge clk);
      check("b2b_rdy0", in_ready, 1);
      @(posedge clk); #1;
      in_data = 16'h0003;
      @(negedge clk);
      check("b2b_rdy1", in_ready, 1);
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      check("b2b_rdy2",   in_ready,  1);
      check("b2b_valid0", out_valid, 1);
      check("b2b_sum0",   out_sum,   4);
      @(negedge clk);
      check("b2b_valid1", out_valid, 1);
      check("b2b_sum1",   out_sum,   2);
      check("b2b_words1", out_words, 1);
      @(negedge clk);
      check("b2b_idle",   out_valid, 0);
      @(posedge clk); #1;

      // Overflow: 17 words of 0xFFFF = 272 set bits into an 8-bit sum.
`ifdef POPCNT_SAT_EN
      exp_q.push_back(pack(255, 17, 1'b1));
`else
      exp_q.push_back(pack(16, 17, 1'b0));
`endif
      for (int i = 0; i < 17; i++) send_word(16'hFFFF, (i == 16));
      idle();
      cycles(4);
      check("ovf_drained", exp_q.size(), 0);

      // Mid-frame reset discards the partial frame.
      send_word(16'h00FF, 1'b0);
      send_word(16'h00FF, 1'b0);
      idle();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mrst_out_valid", out_valid, 0);
      check("mrst_in_ready",  in_ready,  1);
      @(posedge clk); #1;
      exp_q.push_back(pack(2, 1, 1'b0));
      send_word(16'h0003, 1'b1);
      idle();
      @(negedge clk);
      @(negedge clk);
      check("mrst_valid", out_valid, 1);
      check("mrst_sum",   out_sum,   2);
      check("mrst_words", out_words, 1);
      cycles(4);
      check("final_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
